// File: rtl/ps2_keyboard_rx_if.sv
// ============================================================================
// Module  : ps2_keyboard_rx_if
// Brief   : PS/2 line inputs and received-byte outputs of the keyboard receiver.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface ps2_keyboard_rx_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic        newchar;
    logic [15:0] char;
    logic        frame_err;

    // master drives the PS/2 lines and consumes the received bytes
    modport master (
        output ps2_clk,
        output ps2_data,
        input  newchar,
        input  char,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output newchar,
        output char,
        output frame_err
    );
endinterface

`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
// ============================================================================
// Module  : ps2_keyboard_rx
// Brief   : PS/2 keyboard frame receiver with clock-line glitch filter and
//           inter-bit timeout. Define PS2_PARITY_CHECK_EN to drop bad-parity frames.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    ps2_keyboard_rx_if.slave bus
);

    localparam int c_FW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam int c_TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [c_FW-1:0] c_FILT_LAST = c_FW'(FILTER_LEN - 1);
    localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DATA   = 2'd1;
    localparam logic [1:0] c_PARITY = 2'd2;
    localparam logic [1:0] c_STOP   = 2'd3;

    logic            r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
    logic            r_clk_filt;
    logic [c_FW-1:0] r_filt_cnt;
    logic [1:0]      r_state, w_state_nxt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [c_TW-1:0] r_to_cnt;
    logic [15:0]     r_char;
    logic            r_newchar, r_frame_err;

    logic w_filt_flip, w_bit_edge, w_timeout, w_parity_ok;
    logic w_frame_start, w_shift_en, w_parity_en, w_accept, w_reject;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= bus.ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= bus.ps2_data;
            r_dat_sync <= r_dat_meta;
        end
    end

    // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
    assign w_filt_flip = (r_clk_sync != r_clk_filt) && (r_filt_cnt == c_FILT_LAST);
    assign w_bit_edge  = w_filt_flip && r_clk_filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_sync == r_clk_filt) begin
            r_filt_cnt <= '0;
        end else if (w_filt_flip) begin
            r_clk_filt <= ~r_clk_filt;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    // A bit edge in the same cycle always wins over an expiring timeout.
    assign w_timeout = (r_state != c_IDLE) && !w_bit_edge && (r_to_cnt == c_TO_LAST);

`ifdef PS2_PARITY_CHECK_EN
    assign w_parity_ok = ^{r_shift, r_parity};
`else
    logic w_unused_parity;
    assign w_unused_parity = r_parity;
    assign w_parity_ok     = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_bit_edge && !r_dat_sync) w_state_nxt = c_DATA;
            c_DATA:   if (w_bit_edge && (r_bit_cnt == 3'd7)) w_state_nxt = c_PARITY;
                      else if (w_timeout) w_state_nxt = c_IDLE;
            c_PARITY: if (w_bit_edge) w_state_nxt = c_STOP;
                      else if (w_timeout) w_state_nxt = c_IDLE;
            c_STOP:   if (w_bit_edge || w_timeout) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_frame_start = 1'b0;
        w_shift_en    = 1'b0;
        w_parity_en   = 1'b0;
        w_accept      = 1'b0;
        w_reject      = 1'b0;
        case (r_state)
            c_IDLE:   w_frame_start = w_bit_edge && !r_dat_sync;
            c_DATA:   w_shift_en    = w_bit_edge;
            c_PARITY: w_parity_en   = w_bit_edge;
            c_STOP: begin
                w_accept = w_bit_edge && r_dat_sync && w_parity_ok;
                w_reject = w_bit_edge && !(r_dat_sync && w_parity_ok);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
        end else if (w_frame_start) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
        end else if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_shift   <= {r_dat_sync, r_shift[7:1]};
        end else if (w_parity_en) begin
            r_parity  <= r_dat_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if ((r_state == c_IDLE) || w_bit_edge || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_char      <= 16'h0000;
            r_newchar   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_newchar   <= w_accept;
            r_frame_err <= w_reject || w_timeout;
            if (w_accept) begin
                r_char <= {r_char[7:0], r_shift};
            end
        end
    end

    assign bus.newchar   = r_newchar;
    assign bus.char      = r_char;
    assign bus.frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
// ============================================================================
// Module  : tb_ps2_keyboard_rx
// Brief   : Self-checking bench: directed frame table, randomized frames against
//           a byte-level model, and timeout / glitch / mid-frame reset sequences.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_keyboard_rx;

    localparam int FL   = 4;
    localparam int TO   = 1000;
    localparam int HALF = 20;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    typedef struct {
        logic [7:0]  d;
        logic        p;
        logic        s;
        int          exp_nc;
        int          exp_err;
        logic [15:0] exp_char;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_keyboard_rx_if bus ();

    ps2_keyboard_rx #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int nc_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [15:0] m_char = 16'h0000;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.newchar)                  nc_cnt   <= nc_cnt + 1;
            if (bus.frame_err)                err_cnt  <= err_cnt + 1;
            if (bus.newchar && bus.frame_err) both_cnt <= both_cnt + 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // bits[0] goes out first; data changes mid-high, edge in the middle of the bit
    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.ps2_data = bits[i];
            repeat (HALF / 2) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b1;
            repeat (HALF / 2) @(negedge clk);
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic frame_check(input string name, input logic [7:0] d, input logic p,
                               input logic s, input int exp_nc, input int exp_err,
                               input logic [15:0] exp_char);
        int nc0, e0;
        nc0 = nc_cnt;
        e0  = err_cnt;
        send_bits({s, p, d, 1'b0}, 11);
        repeat (30) @(negedge clk);
        check({name, ".newchar"}, nc_cnt - nc0, exp_nc);
        check({name, ".frame_err"}, err_cnt - e0, exp_err);
        check({name, ".char"}, {16'h0, bus.char}, {16'h0, exp_char});
        m_char = exp_char;
    endtask

    vec_t tbl[6];

    initial begin
        int nc0, e0;
        logic [7:0] d;
        logic p, s, good_p, valid;

        tbl[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 16'h001C};
        tbl[1] = '{8'hF0, 1'b1, 1'b1, 1, 0, 16'h1CF0};
        tbl[2] = '{8'h1C, 1'b0, 1'b1, 1, 0, 16'hF01C};
        tbl[3] = '{8'h1C, 1'b1, 1'b1, PCHK ? 0 : 1, PCHK ? 1 : 0,
                   PCHK ? 16'hF01C : 16'h1C1C};
        tbl[4] = '{8'h5A, 1'b1, 1'b0, 0, 1, PCHK ? 16'hF01C : 16'h1C1C};
        tbl[5] = '{8'hE0, 1'b0, 1'b1, 1, 0, 16'h1CE0};

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("reset.char", {16'h0, bus.char}, 32'h0);
        check("reset.newchar", {31'h0, bus.newchar}, 32'h0);
        check("reset.frame_err", {31'h0, bus.frame_err}, 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            frame_check($sformatf("vec%0d", i), tbl[i].d, tbl[i].p, tbl[i].s,
                        tbl[i].exp_nc, tbl[i].exp_err, tbl[i].exp_char);
        end

        // randomized frames against a byte-level model
        for (int i = 0; i < 40; i++) begin
            d      = 8'($urandom_range(0, 255));
            good_p = ($countones(d) % 2) == 0;
            p      = ($urandom_range(0, 3) == 0) ? ~good_p : good_p;
            s      = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            valid  = s && (!PCHK || (($countones({d, p}) % 2) == 1));
            frame_check($sformatf("rnd%0d", i), d, p, s, valid ? 1 : 0, valid ? 0 : 1,
                        valid ? {m_char[7:0], d} : m_char);
        end

        // start bit + 4 data bits, then the clock line stalls high
        nc0 = nc_cnt;
        e0  = err_cnt;
        send_bits(11'b000_0000_1010, 5);
        repeat (TO + 10) @(negedge clk);
        check("timeout.frame_err", err_cnt - e0, 1);
        check("timeout.newchar", nc_cnt - nc0, 0);
        check("timeout.char", {16'h0, bus.char}, {16'h0, m_char});
        frame_check("after_timeout", 8'h16, 1'b0, 1'b1, 1, 0, {m_char[7:0], 8'h16});

        // clock glitch shorter than the filter, with data low as if a start bit
        nc0 = nc_cnt;
        e0  = err_cnt;
        @(negedge clk);
        bus.ps2_data = 1'b0;
        bus.ps2_clk  = 1'b0;
        repeat (FL - 1) @(negedge clk);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch.newchar", nc_cnt - nc0, 0);
        check("glitch.frame_err", err_cnt - e0, 0);
        frame_check("after_glitch", 8'h45, 1'b0, 1'b1, 1, 0, {m_char[7:0], 8'h45});

        // reset in the middle of a frame
        nc0 = nc_cnt;
        send_bits({1'b1, 1'b0, 8'h77, 1'b0}, 6);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset.char", {16'h0, bus.char}, 32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midreset.newchar", nc_cnt - nc0, 0);
        m_char = 16'h0000;
        frame_check("after_reset", 8'h29, 1'b0, 1'b1, 1, 0, 16'h0029);

        check("newchar_frame_err_exclusive", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
